serdes_align_ctrl: RTL and testbench

- Word-alignment sequencer for a DPA-mode I_SERDES receive lane.
- Waits for DPA lock, then compares deserialized words against a known training pattern. On mismatch it pulses BITSLIP_ADJ and waits for the slip to settle, repeating until the pattern matches or every bit position has been tried.
- Sits in the fabric_clk_div domain between the SERDES outputs (Q, DATA_VALID, DPA_LOCK) and the fabric data register; its `aligned` output gates downstream capture.

---
 rtl/serdes_align_ctrl.sv | 231 +++++++++++++++++++++++
 tb/tb_serdes_align_ctrl.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/serdes_align_ctrl.sv
// Word-alignment sequencer for a DPA-mode SERDES receive lane.
// Optional: define ALIGN_MONITOR_EN to watch the aligned lane and re-align after MATCH_COUNT bad words.
//
// state      | meaning
// -----------+----------------------------------------------------------
// IDLE       | start low, everything cleared
// WAIT_LOCK  | waiting for DPA lock, lock timer running
// CHECK      | comparing valid words against the training pattern
// SLIP       | one-cycle bitslip request to the SERDES
// SETTLE     | waiting for the slip to take effect, data ignored
// ALIGNED    | pattern matched MATCH_COUNT times, lane usable
// FAIL       | lock timeout or every bit position tried, held until start low
module serdes_align_ctrl #(
  parameter int unsigned       WIDTH         = 10,
  parameter logic [WIDTH-1:0]  TRAIN_PATTERN = 10'h3E0,
  parameter int unsigned       MATCH_COUNT   = 4,
  parameter int unsigned       SETTLE_CYCLES = 8,
  parameter int unsigned       LOCK_TIMEOUT  = 255
) (
  input  logic             fabric_clk_div,
  input  logic             reset_buf_n,
  input  logic             start,
  input  logic             dpa_lock,
  input  logic             data_valid,
  input  logic [WIDTH-1:0] rx_data,
  output logic             bitslip_adj,
  output logic             aligned,
  output logic             align_fail,
  output logic             busy,
  output logic [3:0]       slip_count,
  output logic [7:0]       realign_count
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_LOCK,
    ST_CHECK,
    ST_SLIP,
    ST_SETTLE,
    ST_ALIGNED,
    ST_FAIL
  } state_t;

  // Timers are down-counters loaded with (length-1) and compared against zero.
  localparam logic [15:0] LOCK_LOAD   = 16'(LOCK_TIMEOUT - 1);
  localparam logic [15:0] SETTLE_LOAD = 16'(SETTLE_CYCLES - 1);
  localparam logic [3:0]  MATCH_LAST  = 4'(MATCH_COUNT - 1);
  localparam logic [3:0]  SLIP_LAST   = 4'(WIDTH - 1);

  state_t      state;
  state_t      state_nxt;
  logic [15:0] timer;
  logic [15:0] timer_nxt;
  logic [3:0]  match_cnt;
  logic [3:0]  match_nxt;
  logic [3:0]  slip_cnt;
  logic [3:0]  slip_nxt;
  logic        word_ok;
  logic        lock_lost;
  logic        bitslip_nxt;
  logic        aligned_nxt;
  logic        fail_nxt;
  logic        busy_nxt;

`ifdef ALIGN_MONITOR_EN
  logic [3:0]  mon_cnt;
  logic [3:0]  mon_nxt;
  logic [7:0]  realign_cnt;
  logic [7:0]  realign_nxt;
`endif

  assign word_ok   = (rx_data == TRAIN_PATTERN);
  assign lock_lost = !dpa_lock &&
                     ((state == ST_CHECK) || (state == ST_SLIP) ||
                      (state == ST_SETTLE) || (state == ST_ALIGNED));

  always_ff @(posedge fabric_clk_div or negedge reset_buf_n) begin
    if (!reset_buf_n) begin
      state       <= ST_IDLE;
      timer       <= '0;
      match_cnt   <= '0;
      slip_cnt    <= '0;
      bitslip_adj <= 1'b0;
      aligned     <= 1'b0;
      align_fail  <= 1'b0;
      busy        <= 1'b0;
`ifdef ALIGN_MONITOR_EN
      mon_cnt     <= '0;
      realign_cnt <= '0;
`endif
    end else begin
      state       <= state_nxt;
      timer       <= timer_nxt;
      match_cnt   <= match_nxt;
      slip_cnt    <= slip_nxt;
      bitslip_adj <= bitslip_nxt;
      aligned     <= aligned_nxt;
      align_fail  <= fail_nxt;
      busy        <= busy_nxt;
`ifdef ALIGN_MONITOR_EN
      mon_cnt     <= mon_nxt;
      realign_cnt <= realign_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    match_nxt = match_cnt;
    slip_nxt  = slip_cnt;
`ifdef ALIGN_MONITOR_EN
    mon_nxt     = mon_cnt;
    realign_nxt = realign_cnt;
`endif
    if ((state != ST_IDLE) && !start) begin
      state_nxt = ST_IDLE;
      timer_nxt = '0;
      match_nxt = '0;
      slip_nxt  = '0;
`ifdef ALIGN_MONITOR_EN
      mon_nxt   = '0;
`endif
    end else if (lock_lost) begin
      state_nxt = ST_WAIT_LOCK;
      timer_nxt = LOCK_LOAD;
      match_nxt = '0;
      slip_nxt  = '0;
`ifdef ALIGN_MONITOR_EN
      mon_nxt   = '0;
`endif
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            state_nxt = ST_WAIT_LOCK;
            timer_nxt = LOCK_LOAD;
            match_nxt = '0;
            slip_nxt  = '0;
          end
        end
        ST_WAIT_LOCK: begin
          if (dpa_lock) begin
            state_nxt = ST_CHECK;
            match_nxt = '0;
          end else if (timer == '0) begin
            state_nxt = ST_FAIL;
          end else begin
            timer_nxt = timer - 16'd1;
          end
        end
        ST_CHECK: begin
          if (data_valid) begin
            if (word_ok) begin
              match_nxt = match_cnt + 4'd1;
              if (match_cnt == MATCH_LAST) begin
                state_nxt = ST_ALIGNED;
`ifdef ALIGN_MONITOR_EN
                mon_nxt   = '0;
`endif
              end
            end else if (slip_cnt == SLIP_LAST) begin
              state_nxt = ST_FAIL;
            end else begin
              state_nxt = ST_SLIP;
              slip_nxt  = slip_cnt + 4'd1;
            end
          end
        end
        ST_SLIP: begin
          state_nxt = ST_SETTLE;
          timer_nxt = SETTLE_LOAD;
        end
        ST_SETTLE: begin
          if (timer == '0) begin
            state_nxt = ST_CHECK;
            match_nxt = '0;
          end else begin
            timer_nxt = timer - 16'd1;
          end
        end
        ST_ALIGNED: begin
`ifdef ALIGN_MONITOR_EN
          if (data_valid) begin
            if (word_ok) begin
              mon_nxt = '0;
            end else if (mon_cnt == MATCH_LAST) begin
              state_nxt = ST_CHECK;
              match_nxt = '0;
              mon_nxt   = '0;
              if (realign_cnt != 8'hFF) begin
                realign_nxt = realign_cnt + 8'd1;
              end
            end else begin
              mon_nxt = mon_cnt + 4'd1;
            end
          end
`endif
        end
        ST_FAIL: begin
        end
        default: begin
          state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  // Status flops are loaded from the next state so they track the state register exactly.
  always_comb begin
    bitslip_nxt = (state_nxt == ST_SLIP);
    aligned_nxt = (state_nxt == ST_ALIGNED);
    fail_nxt    = (state_nxt == ST_FAIL);
    busy_nxt    = (state_nxt == ST_WAIT_LOCK) || (state_nxt == ST_CHECK) ||
                  (state_nxt == ST_SLIP) || (state_nxt == ST_SETTLE);
  end

  assign slip_count = slip_cnt;

`ifdef ALIGN_MONITOR_EN
  assign realign_count = realign_cnt;
`else
  assign realign_count = 8'd0;
`endif

  a_bitslip_single: assert property (@(posedge fabric_clk_div) disable iff (!reset_buf_n)
    bitslip_adj |=> !bitslip_adj);
  a_status_exclusive: assert property (@(posedge fabric_clk_div) disable iff (!reset_buf_n)
    !(aligned && align_fail));

endmodule

// File: tb/tb_serdes_align_ctrl.sv
// Bench for serdes_align_ctrl: table vectors, randomized lanes against a rotating-channel model,
// and hand sequences for lock timeout, lock loss, async reset and (if compiled in) the monitor.
module tb_serdes_align_ctrl;
  localparam int W  = 10;
  localparam logic [W-1:0] PAT = 10'h3E0;
  localparam int MC = 4;
  localparam int SC = 8;
  localparam int LT = 255;

  logic          fabric_clk_div = 1'b0;
  logic          reset_buf_n    = 1'b0;
  logic          start          = 1'b0;
  logic          dpa_lock       = 1'b0;
  logic          data_valid     = 1'b0;
  logic [W-1:0]  rx_data        = '0;
  logic          bitslip_adj;
  logic          aligned;
  logic          align_fail;
  logic          busy;
  logic [3:0]    slip_count;
  logic [7:0]    realign_count;

  int checks = 0;
  int errors = 0;

  always #5 fabric_clk_div = ~fabric_clk_div;

  serdes_align_ctrl #(
    .WIDTH(W), .TRAIN_PATTERN(PAT), .MATCH_COUNT(MC),
    .SETTLE_CYCLES(SC), .LOCK_TIMEOUT(LT)
  ) dut (
    .fabric_clk_div(fabric_clk_div),
    .reset_buf_n(reset_buf_n),
    .start(start),
    .dpa_lock(dpa_lock),
    .data_valid(data_valid),
    .rx_data(rx_data),
    .bitslip_adj(bitslip_adj),
    .aligned(aligned),
    .align_fail(align_fail),
    .busy(busy),
    .slip_count(slip_count),
    .realign_count(realign_count)
  );

  typedef struct {
    int           rot;
    bit           cmode;
    logic [W-1:0] cword;
    int           dv_per;
    int           lock_dly;
    int           exp_pulses;
    bit           exp_al;
    bit           exp_fail;
    int           exp_slips;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_bitslip"}, bitslip_adj, 0);
    check({tag, "_aligned"}, aligned, 0);
    check({tag, "_fail"}, align_fail, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_slipcnt"}, slip_count, 0);
  endtask

  task automatic go_idle(input string tag);
    @(negedge fabric_clk_div);
    start = 1'b0; dpa_lock = 1'b0; data_valid = 1'b0;
    @(negedge fabric_clk_div);
    check_idle(tag);
  endtask

  function automatic logic [W-1:0] rotl(input logic [W-1:0] v, input int n);
    logic [W-1:0] r;
    r = v;
    for (int i = 0; i < n; i++) r = {r[W-2:0], r[W-1]};
    return r;
  endfunction

  // Channel model: the lane starts rot positions off and every observed slip moves it one closer.
  // Expected aligned rise: the cycle after the MC-th matching valid word presented once the
  // controller can be comparing (one cycle after lock, or SC+1 cycles after the last slip pulse).
  task automatic run_align(input int rot, input bit cmode, input logic [W-1:0] cword,
                           input int dv_per, input int lock_dly, input int budget,
                           output int pulses, output int min_gap, output bit back2back,
                           output bit rise_ok);
    int slips, last_pulse, count_from, vcnt, exp_rise, rise_at;
    bit prev_bs, dv;
    slips = 0; last_pulse = -1000; count_from = -1; vcnt = 0;
    exp_rise = -1; rise_at = -1; prev_bs = 1'b0;
    pulses = 0; min_gap = 1000; back2back = 1'b0;
    for (int n = 0; n < budget; n++) begin
      @(negedge fabric_clk_div);
      if (bitslip_adj) begin
        if (prev_bs) back2back = 1'b1;
        if (pulses > 0 && (n - last_pulse) < min_gap) min_gap = n - last_pulse;
        pulses++; slips++; last_pulse = n;
        count_from = n + SC + 1; vcnt = 0;
      end
      prev_bs = bitslip_adj;
      if (aligned && rise_at < 0) rise_at = n;
      if (aligned || align_fail) break;
      start = 1'b1;
      dpa_lock = (n >= lock_dly);
      if (n == lock_dly) count_from = n + 1;
      dv = (dv_per == 0) ? 1'($urandom_range(0, 1)) : ((n % dv_per) == 0);
      data_valid = dv;
      if (!dv) rx_data = W'($urandom);
      else if (cmode) rx_data = cword;
      else rx_data = rotl(PAT, (rot + W - (slips % W)) % W);
      if (dv && count_from >= 0 && n >= count_from) begin
        if (rx_data == PAT) begin
          vcnt++;
          if (vcnt == MC && exp_rise < 0) exp_rise = n + 1;
        end else begin
          vcnt = 0;
        end
      end
    end
    rise_ok = (rise_at == exp_rise);
  endtask

  initial begin
    vec_t vecs[6];
    int   pulses, gap, r, ld, n0, n1;
    bit   b2b, rok, seen;

    vecs[0] = '{3, 1'b0, 10'h000, 1, 5, 3, 1'b1, 1'b0, 3};
    vecs[1] = '{0, 1'b0, 10'h000, 1, 2, 0, 1'b1, 1'b0, 0};
    vecs[2] = '{9, 1'b0, 10'h000, 2, 3, 9, 1'b1, 1'b0, 9};
    vecs[3] = '{0, 1'b1, 10'h155, 1, 4, 9, 1'b0, 1'b1, 9};
    vecs[4] = '{0, 1'b0, 10'h000, 3, 1, 0, 1'b1, 1'b0, 0};
    vecs[5] = '{5, 1'b0, 10'h000, 3, 7, 5, 1'b1, 1'b0, 5};

    repeat (3) @(negedge fabric_clk_div);
    check_idle("reset");
    check("reset_realign", realign_count, 0);
    reset_buf_n = 1'b1;
    @(negedge fabric_clk_div);

    for (int i = 0; i < 6; i++) begin
      run_align(vecs[i].rot, vecs[i].cmode, vecs[i].cword, vecs[i].dv_per,
                vecs[i].lock_dly, 600, pulses, gap, b2b, rok);
      check($sformatf("vec%0d_pulses", i), pulses, vecs[i].exp_pulses);
      check($sformatf("vec%0d_aligned", i), aligned, vecs[i].exp_al);
      check($sformatf("vec%0d_fail", i), align_fail, vecs[i].exp_fail);
      check($sformatf("vec%0d_slipcnt", i), slip_count, vecs[i].exp_slips);
      check($sformatf("vec%0d_rise", i), rok, 1);
      check($sformatf("vec%0d_gap", i), (pulses < 2) || (gap >= SC + 2), 1);
      check($sformatf("vec%0d_b2b", i), b2b, 0);
      check($sformatf("vec%0d_busy", i), busy, 0);
      go_idle($sformatf("vec%0d_idle", i));
    end
    check("realign_untouched", realign_count, 0);

    for (int t = 0; t < 20; t++) begin
      r  = $urandom_range(0, W - 1);
      ld = $urandom_range(1, 20);
      run_align(r, 1'b0, '0, 0, ld, 800, pulses, gap, b2b, rok);
      check($sformatf("rnd%0d_pulses", t), pulses, r);
      check($sformatf("rnd%0d_aligned", t), aligned, 1);
      check($sformatf("rnd%0d_slipcnt", t), slip_count, r);
      check($sformatf("rnd%0d_rise", t), rok, 1);
      check($sformatf("rnd%0d_gap", t), (pulses < 2) || (gap >= SC + 2), 1);
      check($sformatf("rnd%0d_b2b", t), b2b, 0);
      go_idle($sformatf("rnd%0d_idle", t));
    end

    // Lock timeout: FAIL exactly LT cycles after WAIT_LOCK is entered, no slips.
    @(negedge fabric_clk_div);
    start = 1'b1; dpa_lock = 1'b0; data_valid = 1'b0;
    n0 = -1; n1 = -1; seen = 1'b0;
    for (int n = 1; n < 400; n++) begin
      @(negedge fabric_clk_div);
      if (bitslip_adj) seen = 1'b1;
      if (busy && n0 < 0) n0 = n;
      if (align_fail) begin n1 = n; break; end
    end
    check("lockto_cycles", n1 - n0, LT);
    check("lockto_noslip", seen, 0);
    check("lockto_busy", busy, 0);
    go_idle("lockto_idle");

    // Lock loss from ALIGNED, then a fresh sequence on relock.
    run_align(2, 1'b0, '0, 1, 3, 600, pulses, gap, b2b, rok);
    check("drop_pre_aligned", aligned, 1);
    check("drop_pre_slipcnt", slip_count, 2);
    dpa_lock = 1'b0;
    @(negedge fabric_clk_div);
    check("drop_aligned", aligned, 0);
    check("drop_slipcnt", slip_count, 0);
    check("drop_busy", busy, 1);
    run_align(4, 1'b0, '0, 1, 6, 600, pulses, gap, b2b, rok);
    check("relock_pulses", pulses, 4);
    check("relock_aligned", aligned, 1);
    check("relock_slipcnt", slip_count, 4);
    check("relock_rise", rok, 1);
    go_idle("relock_idle");

    // Asynchronous reset in the middle of SETTLE.
    @(negedge fabric_clk_div);
    start = 1'b1; dpa_lock = 1'b1; data_valid = 1'b1; rx_data = rotl(PAT, 3);
    seen = 1'b0;
    for (int n = 0; n < 50; n++) begin
      @(negedge fabric_clk_div);
      if (bitslip_adj) begin seen = 1'b1; break; end
    end
    check("arst_pulse_seen", seen, 1);
    repeat (3) @(negedge fabric_clk_div);
    check("arst_pre_busy", busy, 1);
    check("arst_pre_slipcnt", slip_count, 1);
    #2 reset_buf_n = 1'b0;
    #1 check_idle("arst");
    start = 1'b0; dpa_lock = 1'b0; data_valid = 1'b0;
    @(negedge fabric_clk_div);
    reset_buf_n = 1'b1;
    run_align(1, 1'b0, '0, 1, 4, 600, pulses, gap, b2b, rok);
    check("arst_seq_pulses", pulses, 1);
    check("arst_seq_aligned", aligned, 1);
    check("arst_seq_slipcnt", slip_count, 1);
    check("arst_seq_rise", rok, 1);
    go_idle("arst_idle");

`ifdef ALIGN_MONITOR_EN
    run_align(0, 1'b0, '0, 1, 2, 600, pulses, gap, b2b, rok);
    check("mon_aligned", aligned, 1);
    for (int k = 0; k < 8; k++) begin
      data_valid = 1'b1;
      rx_data = (k == 3 || k == 7) ? PAT : ~PAT;
      @(negedge fabric_clk_div);
    end
    check("mon_hold_aligned", aligned, 1);
    check("mon_hold_realign", realign_count, 0);
    for (int k = 0; k < 4; k++) begin
      data_valid = 1'b1; rx_data = ~PAT;
      @(negedge fabric_clk_div);
      if (k < 3) check($sformatf("mon_bad%0d_aligned", k), aligned, 1);
    end
    check("mon_drop_aligned", aligned, 0);
    check("mon_drop_realign", realign_count, 1);
    check("mon_drop_busy", busy, 1);
    rx_data = PAT;
    seen = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge fabric_clk_div);
      if (aligned) begin seen = 1'b1; break; end
    end
    check("mon_realigned", seen, 1);
    check("mon_realign_slipcnt", slip_count, 0);
    check("mon_realign_count", realign_count, 1);
    go_idle("mon_idle");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
